wb_select_stage: RTL
====================

WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result/source width in bits.
REQ-002 SHALL have parameter NSRC, default 4, number of result sources (range 2..8).
REQ-003 SHALL have parameter REG_AW, default 5, destination register index width.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  instruction present from MEM stage.
REQ-007 SHALL have port stall  input  1  hold stage contents.
REQ-008 SHALL have port flush  input  1  replace stage contents with bubble.
REQ-009 SHALL have port src_data  input  NSRC*DATA_W  packed sources; source k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port src_sel  input  $clog2(NSRC)  binary source index.
REQ-011 SHALL have port in_rd  input  REG_AW  destination register index.
REQ-012 SHALL have port in_we  input  1  register write request.
REQ-013 SHALL have port ld_size  input  2  00 byte, 01 half, 1x word.
REQ-014 SHALL have port ld_signed  input  1  sign-extend sub-word loads.
REQ-015 SHALL have port ld_addr_lo  input  2  load address bits [1:0].
REQ-016 SHALL have outputs wb_valid 1, wb_we 1, wb_rd REG_AW, wb_data DATA_W: registered write-back bundle.
REQ-017 SHALL have outputs sel_err 1 (sticky illegal-select flag) and retire_cnt 32 (retired-instruction count).

Function
REQ-018 SHALL capture on rising clk, latency exactly 1 cycle from inputs to wb_* outputs.
REQ-019 Priority SHALL be flush > stall > capture.
REQ-020 flush SHALL clear wb_valid and wb_we; wb_rd and wb_data SHALL hold.
REQ-021 stall (no flush) SHALL hold all registered outputs, sel_err and retire_cnt unchanged.
REQ-022 Capture SHALL load wb_valid=in_valid, wb_rd=in_rd, wb_data=selected source, wb_we=in_valid & in_we & (in_rd != 0).
REQ-023 src_sel >= NSRC SHALL select source 0; if captured with in_valid=1 SHALL set sel_err.
REQ-024 sel_err SHALL stay set until reset.
REQ-025 retire_cnt SHALL increment by 1 on each capture with in_valid=1, wrapping 0xFFFFFFFF -> 0.
REQ-026 Flushed or stalled cycles SHALL NOT increment retire_cnt.

Reset
REQ-027 rst_n low SHALL immediately force wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, sel_err=0, retire_cnt=0, regardless of clk.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both; first capture occurs on first rising clk with rst_n high.

Configuration
REQ-029 Macro WB_LOAD_ALIGN_EN defined: source 1 SHALL pass through load alignment before selection (little-endian; byte lane = ld_addr_lo, half lane = ld_addr_lo[1]; zero- or sign-extend per ld_signed; word unchanged); requires DATA_W=32.
REQ-030 Macro undefined: source 1 SHALL pass unmodified; ld_size, ld_signed, ld_addr_lo SHALL be ignored but present.

Structure
REQ-031 Package wb_pkg SHALL hold ld_size encodings (LD_BYTE, LD_HALF, LD_WORD) and source indices SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_IMM=3.
REQ-032 Load alignment SHALL be a combinational sub-module wb_load_align, instantiated only under WB_LOAD_ALIGN_EN.

Verification
REQ-033 Capture: in_valid=1, src_sel=2, source 2=0x00400008, in_rd=31, in_we=1 -> next cycle wb_data=0x00400008, wb_rd=31, wb_we=1, retire_cnt=1.
REQ-034 Zero register: in_rd=0, in_we=1, in_valid=1 -> wb_we=0, wb_valid=1, retire_cnt increments.
REQ-035 Stall/flush: stall=1 three cycles -> outputs and retire_cnt frozen; stall=1 with flush=1 -> wb_valid=0, wb_we=0, retire_cnt frozen.
REQ-036 Illegal select (NSRC=3): src_sel=3, in_valid=1, source 0=0xDEADBEEF -> wb_data=0xDEADBEEF, sel_err=1 persisting after later legal selects.
REQ-037 Load align (macro on): source 1=0x12F4_5678, src_sel=1, ld_size=00, ld_addr_lo=2, ld_signed=1 -> wb_data=0xFFFFFFF4; ld_signed=0 -> 0x000000F4; macro off -> 0x12F45678.
REQ-038 Reset/wrap: preload retire_cnt to 0xFFFFFFFF, one valid capture -> 0; assert rst_n low between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back select stage.
// Load size codes and result source indices.
package wb_pkg;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  localparam int CNT_W = 32;

endpackage

// File: rtl/wb_select_stage_if.sv
// MEM->WB bundle and registered write-back outputs.
// master drives the stage inputs, slave is the stage.
interface wb_select_stage_if #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int REG_AW = 5
);
  localparam int SW = $clog2(NSRC);

  logic                   in_valid;
  logic                   stall;
  logic                   flush;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [SW-1:0]          src_sel;
  logic [REG_AW-1:0]      in_rd;
  logic                   in_we;
  logic [1:0]             ld_size;
  logic                   ld_signed;
  logic [1:0]             ld_addr_lo;
  logic                   wb_valid;
  logic                   wb_we;
  logic [REG_AW-1:0]      wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic                   sel_err;
  logic [31:0]            retire_cnt;

  modport master (
    output in_valid, stall, flush, src_data, src_sel,
    output in_rd, in_we, ld_size, ld_signed, ld_addr_lo,
    input  wb_valid, wb_we, wb_rd, wb_data, sel_err, retire_cnt
  );

  modport slave (
    input  in_valid, stall, flush, src_data, src_sel,
    input  in_rd, in_we, ld_size, ld_signed, ld_addr_lo,
    output wb_valid, wb_we, wb_rd, wb_data, sel_err, retire_cnt
  );

endinterface

// File: rtl/wb_load_align.sv
// Little-endian load alignment for 32-bit loads.
// Extracts byte/half lane and zero- or sign-extends.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  output logic [31:0] out
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane, then extend to the full word.
  always_comb begin
    lane_b = data[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? data[31:16] : data[15:0];
    out    = data;
    unique case (1'b1)
      (size == LD_BYTE):
        out = {{24{sgn & lane_b[7]}}, lane_b};
      (size == LD_HALF):
        out = {{16{sgn & lane_h[15]}}, lane_h};
      size[1]:
        out = data;
      default:
        out = data;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back select stage: picks one result source and registers it.
// Optional load alignment of source 1 under WB_LOAD_ALIGN_EN.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int REG_AW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [$clog2(NSRC)-1:0] src_sel,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic                   in_we,
  input  logic [1:0]             ld_size,
  input  logic                   ld_signed,
  input  logic [1:0]             ld_addr_lo,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   sel_err,
  output logic [CNT_W-1:0]       retire_cnt
);

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;

`ifdef WB_LOAD_ALIGN_EN
  wb_load_align u_align (
    .data    (src_data[SRC_MEM*DATA_W +: DATA_W]),
    .size    (ld_size),
    .sgn     (ld_signed),
    .addr_lo (ld_addr_lo),
    .out     (src1)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{ld_size, ld_signed, ld_addr_lo};
  assign src1 = src_data[SRC_MEM*DATA_W +: DATA_W];
`endif

  // Source mux; out-of-range selects fall back to source 0.
  always_comb begin
    sel_data = src_data[0 +: DATA_W];
    sel_ok   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(src_sel) == k) begin
        sel_ok   = 1'b1;
        sel_data = (k == SRC_MEM) ? src1
                                  : src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Stage register: flush beats stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      sel_err    <= 1'b0;
      retire_cnt <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      wb_rd    <= in_rd;
      wb_data  <= sel_data;
      wb_we    <= in_valid & in_we & (in_rd != '0);
      if (in_valid) begin
        retire_cnt <= retire_cnt + 1'b1;
        if (!sel_ok)
          sel_err <= 1'b1;
      end
    end
  end

endmodule
